// File: rtl/sign_extend_pkg.sv
// sign_extend_pkg: extension mode encoding and the immediate extension function.
// Latency: none (pure functions and types only).
// Backpressure: n/a.
//
// Contents:
//   ext_mode_e  - 2-bit extension mode (SEXT, ZEXT, UPPER, BRANCH)
//   ext_imm()   - extends a raw immediate of in_w bits to out_w bits
//   EXT_MAX_W   - widest output the function can produce
//   SKID_DEPTH  - fixed depth of the result buffer
// Optional feature macro: SIGN_EXTEND_SHIFT_EN (enables UPPER and BRANCH shifting).
package sign_extend_pkg;

  typedef enum logic [1:0] {
    SEXT   = 2'b00,
    ZEXT   = 2'b01,
    UPPER  = 2'b10,
    BRANCH = 2'b11
  } ext_mode_e;

  localparam int unsigned EXT_MAX_W  = 64;
  localparam int unsigned SKID_DEPTH = 2;

  localparam logic [EXT_MAX_W-1:0] EXT_ONE = {{(EXT_MAX_W-1){1'b0}}, 1'b1};

  // The field widths are runtime arguments so a single function serves any
  // IN_W/OUT_W pair; callers pass elaboration constants, so all the masks and
  // shift amounts below collapse to wiring after synthesis.
  function automatic logic [EXT_MAX_W-1:0] ext_imm(
    input logic [EXT_MAX_W-1:0] raw,
    input int unsigned          in_w,
    input int unsigned          out_w,
    input ext_mode_e            mode
  );
    logic [EXT_MAX_W-1:0] in_mask;
    logic [EXT_MAX_W-1:0] out_mask;
    logic [EXT_MAX_W-1:0] low;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] res;
    logic                 sign;

    in_mask  = (in_w  >= EXT_MAX_W) ? '1 : ((EXT_ONE << in_w)  - EXT_ONE);
    out_mask = (out_w >= EXT_MAX_W) ? '1 : ((EXT_ONE << out_w) - EXT_ONE);

    // Anything above the immediate field is ignored rather than trusted.
    low  = raw & in_mask;
    sign = |(raw & (EXT_ONE << (in_w - 1)));
    sext = sign ? (low | ~in_mask) : low;

    case (mode)
      ZEXT:    res = low;
`ifdef SIGN_EXTEND_SHIFT_EN
      UPPER:   res = low << (out_w - in_w);
      BRANCH:  res = sext << 2;
`endif
      default: res = sext;
    endcase

    return res & out_mask;
  endfunction

endpackage

// File: rtl/ext_skid_buf.sv
// ext_skid_buf: 2-entry in-order result buffer with valid/ready on both sides.
// Latency: a word accepted on edge N is presented (out_valid=1) right after edge N.
// Backpressure: in_ready = not full; it is a function of stored state only, never of out_ready.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   flush               - drop all stored entries on the next edge
//   in_valid/in_ready   - upstream handshake, in_data is the word to store
//   out_valid/out_ready - downstream handshake, out_data is the oldest entry
//   occupancy           - number of stored entries, 0..2
module ext_skid_buf
  import sign_extend_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam logic [1:0] OCC_FULL = 2'(SKID_DEPTH);

  logic [1:0]        occ_q,  occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              push;
  logic              pop;

  // The head register is the output register: out_data comes straight from a
  // flop and keeps its last value once the buffer drains.
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign occupancy = occ_q;

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;

    if (flush) begin
      // Any handshake seen on this edge is dropped along with stored data.
      occ_d = 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_d = in_data;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            // Old head leaves, new word takes its place: stays at one entry.
            head_d = in_data;
          end else if (push) begin
            tail_d = in_data;
            occ_d  = 2'd2;
          end else if (pop) begin
            occ_d  = 2'd0;
          end
        end
        2'd2: begin
          // Full: in_ready is low so no push can occur here; a waiting input
          // is taken on the following edge once a slot has opened.
          if (pop) begin
            head_d = tail_q;
            occ_d  = 2'd1;
          end
        end
        default: begin
          occ_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/sign_extend_pipe.sv
// sign_extend_pipe: extends an IN_W-bit immediate to OUT_W bits in one of four modes.
// Latency: 1 cycle from input acceptance to out_valid; up to 2 results are buffered.
// Backpressure: in_ready drops only when both buffer entries are occupied.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   flush                - discard all buffered results
//   in_valid/in_ready    - input handshake; in_data is the raw immediate, in_mode the mode
//   out_valid/out_ready  - output handshake; out_data is the extended result
//   occupancy            - buffered result count, 0..2
// Optional feature macro: SIGN_EXTEND_SHIFT_EN. When undefined, in_mode[1] is
// ignored (10 behaves as SEXT, 11 as ZEXT) and no shifting logic is built.
module sign_extend_pipe
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       occupancy
);

  // BRANCH needs two spare bits above the field for the shifted sign.
  if (IN_W < 1 || OUT_W < IN_W + 2 || OUT_W > EXT_MAX_W) begin : g_bad_params
    $fatal(1, "sign_extend_pipe: illegal widths IN_W=%0d OUT_W=%0d", IN_W, OUT_W);
  end

  ext_mode_e            mode_dec;
  logic [EXT_MAX_W-1:0] ext_full;
  logic [OUT_W-1:0]     ext_word;

`ifdef SIGN_EXTEND_SHIFT_EN
  assign mode_dec = ext_mode_e'(in_mode);
`else
  // Only the low mode bit selects between sign and zero extension.
  assign mode_dec = in_mode[0] ? ZEXT : SEXT;

  logic unused_mode_hi;
  assign unused_mode_hi = in_mode[1];
`endif

  // Extension happens before storage, so the buffer only ever holds results.
  assign ext_full = ext_imm(EXT_MAX_W'(in_data), IN_W, OUT_W, mode_dec);
  assign ext_word = ext_full[OUT_W-1:0];

  if (OUT_W < EXT_MAX_W) begin : g_unused_hi
    logic unused_ext_hi;
    assign unused_ext_hi = |ext_full[EXT_MAX_W-1:OUT_W];
  end

  ext_skid_buf #(
    .DATA_W (OUT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (ext_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_sign_extend_pipe.sv
// Scoreboard bench for sign_extend_pipe (IN_W=16, OUT_W=32). Expected results are
// hand-computed per vector; the shifted-mode expectations follow SIGN_EXTEND_SHIFT_EN.
module tb_sign_extend_pipe;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       occupancy;

  logic [OUT_W-1:0] exp_word;
  logic [OUT_W-1:0] sb[$];
  int checks   = 0;
  int failures = 0;
  int popped   = 0;

  always #5 clk = ~clk;

  sign_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, predicts what the coming edge transfers.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        popped++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_out: got 0x%0h expected no output", out_data);
        end else begin
          logic [OUT_W-1:0] e;
          e = sb.pop_front();
          if (out_data !== e) begin
            failures++;
            $display("FAIL sb_out: got 0x%0h expected 0x%0h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_word);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    exp_word = e;
    step();
    in_valid = 1'b0;
  endtask

  // One word through an empty buffer with out_ready held high.
  task automatic mode_vec(input string name, input logic [15:0] d, input logic [1:0] m,
                          input logic [31:0] e);
    load(d, m, e);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, out_data, e);
    step();
    check({name, "_idle"}, 32'(out_valid), 32'd0);
    check({name, "_held"}, out_data, e);
  endtask

  initial begin
    int p0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    exp_word  = '0;

    // Reset state
    step();
    step();
    check("rst_occ",   32'(occupancy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  out_data,       32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Modes
    out_ready = 1'b1;
    mode_vec("sext_neg", 16'h8001, 2'b00, 32'hFFFF8001);
    mode_vec("sext_pos", 16'h7FFF, 2'b00, 32'h00007FFF);
    mode_vec("zext",     16'h8001, 2'b01, 32'h00008001);
`ifdef SIGN_EXTEND_SHIFT_EN
    mode_vec("upper",     16'h1234, 2'b10, 32'h12340000);
    mode_vec("upper_neg", 16'h8001, 2'b10, 32'h80010000);
    mode_vec("branch",    16'hFFFF, 2'b11, 32'hFFFFFFFC);
    mode_vec("branch_n",  16'h8001, 2'b11, 32'hFFFE0004);
    mode_vec("branch_p",  16'h2000, 2'b11, 32'h00008000);
`else
    mode_vec("m10_sext", 16'h8001, 2'b10, 32'hFFFF8001);
    mode_vec("m11_zext", 16'h8001, 2'b11, 32'h00008001);
    mode_vec("m10_pos",  16'h1234, 2'b10, 32'h00001234);
    mode_vec("m11_ffff", 16'hFFFF, 2'b11, 32'h0000FFFF);
`endif

    // Backpressure
    out_ready = 1'b0;
    load(16'h0001, 2'b00, 32'h00000001);
    check("bp_occ1", 32'(occupancy), 32'd1);
    check("bp_rdy1", 32'(in_ready),  32'd1);
    load(16'h0002, 2'b00, 32'h00000002);
    check("bp_occ2", 32'(occupancy), 32'd2);
    check("bp_rdy2", 32'(in_ready),  32'd0);
    in_valid = 1'b1;
    in_data  = 16'h0003;
    in_mode  = 2'b00;
    exp_word = 32'h00000003;
    step();
    check("bp_hold_occ",  32'(occupancy), 32'd2);
    check("bp_hold_head", out_data,       32'h00000001);
    out_ready = 1'b1;
    step();
    check("bp_pop_noacc", 32'(occupancy), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_swap_occ", 32'(occupancy), 32'd1);
    step();
    check("bp_drain_occ", 32'(occupancy), 32'd0);

    // Streaming at occupancy 1
    out_ready = 1'b0;
    load(16'hA5A5, 2'b01, 32'h0000A5A5);
    p0 = popped;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data  = 16'h8000 | 16'(k);
      in_mode  = 2'b00;
      exp_word = 32'hFFFF8000 | 32'(k);
      step();
      check($sformatf("stream_occ%0d", k), 32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain", 32'(occupancy), 32'd0);
    check("stream_count", 32'(popped - p0), 32'd9);

    // Flush while full with an input offered
    out_ready = 1'b0;
    load(16'h0011, 2'b00, 32'h00000011);
    load(16'h0022, 2'b00, 32'h00000022);
    check("fl_occ2", 32'(occupancy), 32'd2);
    p0 = popped;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0033;
    exp_word  = 32'h00000033;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_occ",   32'(occupancy), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    step();
    check("fl_no_emit", 32'(popped - p0), 32'd0);

    // Reset mid-stream while full
    out_ready = 1'b0;
    load(16'h0044, 2'b00, 32'h00000044);
    load(16'h0055, 2'b00, 32'h00000055);
    check("rs_occ2", 32'(occupancy), 32'd2);
    p0 = popped;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0066;
    exp_word  = 32'h00000066;
    step();
    in_valid = 1'b0;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_data",  out_data,       32'd0);
    check("rs_occ",   32'(occupancy), 32'd0);
    rst_n = 1'b1;
    step();
    check("rs_in_ready", 32'(in_ready),    32'd1);
    check("rs_no_emit",  32'(popped - p0), 32'd0);

    // Operation resumes after reset
    mode_vec("post_rst", 16'h8001, 2'b01, 32'h00008001);

    step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
